// File: rtl/turn_brake_cmd_gen_if.sv
// Command bus between the driver controls and the turn/brake command generator.
// With TURN_BRAKE_HAZARD_EN defined the bus also carries the raw hazard switch.
interface turn_brake_cmd_gen_if;
   logic brake_sw_i;
   logic stalk_left_i;
   logic stalk_right_i;
   logic cancel_i;
`ifdef TURN_BRAKE_HAZARD_EN
   logic hazard_sw_i;
`endif
   logic brake;
   logic turn_right;
   logic turn_left;

`ifdef TURN_BRAKE_HAZARD_EN
   modport master (output brake_sw_i, stalk_left_i, stalk_right_i, cancel_i, hazard_sw_i,
                   input  brake, turn_right, turn_left);
   modport slave  (input  brake_sw_i, stalk_left_i, stalk_right_i, cancel_i, hazard_sw_i,
                   output brake, turn_right, turn_left);
`else
   modport master (output brake_sw_i, stalk_left_i, stalk_right_i, cancel_i,
                   input  brake, turn_right, turn_left);
   modport slave  (input  brake_sw_i, stalk_left_i, stalk_right_i, cancel_i,
                   output brake, turn_right, turn_left);
`endif
endinterface

// File: rtl/turn_brake_cmd_gen.sv
// Brake/turn command front end: sync + debounce of raw switches, latched self-cancelling turns.
// Optional hazard input enabled by defining TURN_BRAKE_HAZARD_EN.
module turn_brake_cmd_gen #(
   parameter int DEB_CYCLES   = 4,
   parameter int TURN_TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   turn_brake_cmd_gen_if.slave  bus
);
`ifdef TURN_BRAKE_HAZARD_EN
   localparam int NIN  = 4;
   localparam int I_HZ = 3;
`else
   localparam int NIN  = 3;
`endif
   localparam int I_BRK = 0;
   localparam int I_L   = 1;
   localparam int I_R   = 2;
   localparam int CW    = $clog2(DEB_CYCLES);
   localparam int TW    = $clog2(TURN_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [TW-1:0] T_LAST   = TW'(TURN_TIMEOUT - 1);
   localparam logic [TW-1:0] T_MAX    = TW'(TURN_TIMEOUT);

   typedef enum logic [1:0] {IDLE = 2'd0, LEFT = 2'd1, RIGHT = 2'd2} state_t;

   logic [NIN-1:0] raw;
   logic [NIN-1:0] sync1_q, sync2_q;
   logic [NIN-1:0] deb_q, deb_d;
   logic [CW-1:0]  cnt_q [NIN];
   logic [CW-1:0]  cnt_d [NIN];
   logic [1:0]     stk_prev_q;
   state_t         state_q, state_d;
   logic [TW-1:0]  tmr_q, tmr_d;
   logic           l_rise, r_rise, held, hz;

   function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
      return (v == T_MAX) ? v : v + 1'b1;
   endfunction

`ifdef TURN_BRAKE_HAZARD_EN
   assign raw = {bus.hazard_sw_i, bus.stalk_right_i, bus.stalk_left_i, bus.brake_sw_i};
   assign hz  = deb_q[I_HZ];
`else
   assign raw = {bus.stalk_right_i, bus.stalk_left_i, bus.brake_sw_i};
   assign hz  = 1'b0;
`endif

   // Debounce: accept a new level only after DEB_CYCLES consecutive differing samples
   always_comb begin
      for (int i = 0; i < NIN; i++) begin
         deb_d[i] = deb_q[i];
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) deb_d[i] = sync2_q[i];
            else                      cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   assign l_rise = deb_q[I_L] & ~stk_prev_q[0];
   assign r_rise = deb_q[I_R] & ~stk_prev_q[1];

   // Turn FSM: opposite rise > cancel > same-side rise > timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (l_rise && !r_rise)      state_d = LEFT;
            else if (r_rise && !l_rise) state_d = RIGHT;
         end
         LEFT: begin
            if (r_rise)               state_d = RIGHT;
            else if (bus.cancel_i)    state_d = IDLE;
            else if (l_rise)          state_d = IDLE;
            else if (tmr_q == T_LAST) state_d = IDLE;
         end
         RIGHT: begin
            if (l_rise)               state_d = LEFT;
            else if (bus.cancel_i)    state_d = IDLE;
            else if (r_rise)          state_d = IDLE;
            else if (tmr_q == T_LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (hz) state_d = IDLE;

      held = ((state_q == LEFT) && deb_q[I_L]) || ((state_q == RIGHT) && deb_q[I_R]);
      if ((state_d != state_q) || (state_q == IDLE) || held) tmr_d = '0;
      else                                                   tmr_d = sat_inc(tmr_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         stk_prev_q <= '0;
         state_q    <= IDLE;
         tmr_q      <= '0;
         for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q    <= raw;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         stk_prev_q <= {deb_q[I_R], deb_q[I_L]};
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign bus.brake      = deb_q[I_BRK];
   assign bus.turn_left  = (state_q == LEFT)  | hz;
   assign bus.turn_right = (state_q == RIGHT) | hz;
endmodule

// File: tb/tb_turn_brake_cmd_gen.sv
// Directed bench for turn_brake_cmd_gen (DEB_CYCLES=4, TURN_TIMEOUT=64).
// Hazard sequence runs only when TURN_BRAKE_HAZARD_EN is defined.
module tb_turn_brake_cmd_gen;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   turn_brake_cmd_gen_if bus ();

   turn_brake_cmd_gen #(.DEB_CYCLES(4), .TURN_TIMEOUT(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic       brk;
      logic       sl;
      logic       sr;
      logic       cx;
      logic [7:0] n;
      logic       eb;
      logic       el;
      logic       er;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic brk, input logic sl, input logic sr,
                      input logic cx, input int n, input logic eb, input logic el, input logic er);
      vec_t v;
      v.rst = rst; v.brk = brk; v.sl = sl; v.sr = sr; v.cx = cx;
      v.n = 8'(n); v.eb = eb; v.el = el; v.er = er;
      vecs.push_back(v);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic eb, input logic el, input logic er);
      chk({nm, "_brake"}, bus.brake, eb);
      chk({nm, "_left"},  bus.turn_left, el);
      chk({nm, "_right"}, bus.turn_right, er);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus.brake_sw_i = 1'b0; bus.stalk_left_i = 1'b0;
      bus.stalk_right_i = 1'b0; bus.cancel_i = 1'b0;
`ifdef TURN_BRAKE_HAZARD_EN
      bus.hazard_sw_i = 1'b0;
`endif
      // rst brk sl sr cx  n   eb el er
      add(1, 1, 0, 0, 0, 5,  0, 0, 0);   // brake latency
      add(1, 1, 0, 0, 0, 1,  1, 0, 0);
      add(1, 0, 0, 0, 0, 5,  1, 0, 0);
      add(1, 0, 0, 0, 0, 1,  0, 0, 0);
      add(1, 0, 1, 0, 0, 6,  0, 0, 0);   // left latch then timeout
      add(1, 0, 1, 0, 0, 1,  0, 1, 0);
      add(1, 0, 1, 0, 0, 3,  0, 1, 0);
      add(1, 0, 0, 0, 0, 69, 0, 1, 0);
      add(1, 0, 0, 0, 0, 1,  0, 0, 0);
      add(1, 0, 1, 0, 0, 7,  0, 1, 0);   // re-press toggles off
      add(1, 0, 0, 0, 0, 8,  0, 1, 0);
      add(1, 0, 1, 0, 0, 7,  0, 0, 0);
      add(1, 0, 0, 0, 0, 8,  0, 0, 0);
      add(1, 0, 1, 0, 0, 7,  0, 1, 0);   // left -> right, then cancel
      add(1, 0, 0, 1, 0, 6,  0, 1, 0);
      add(1, 0, 0, 1, 0, 1,  0, 0, 1);
      add(1, 0, 0, 1, 1, 1,  0, 0, 0);
      add(1, 0, 0, 0, 0, 8,  0, 0, 0);
      add(1, 0, 0, 1, 0, 7,  0, 0, 1);   // right -> left, then cancel
      add(1, 0, 1, 0, 0, 6,  0, 0, 1);
      add(1, 0, 1, 0, 0, 1,  0, 1, 0);
      add(1, 0, 1, 0, 1, 1,  0, 0, 0);
      add(1, 0, 0, 0, 0, 8,  0, 0, 0);
      add(1, 0, 1, 0, 0, 6,  0, 0, 0);   // cancel in IDLE ignored
      add(1, 0, 1, 0, 1, 1,  0, 1, 0);
      add(1, 0, 1, 0, 0, 1,  0, 1, 0);
      add(1, 0, 1, 0, 1, 1,  0, 0, 0);
      add(1, 0, 0, 0, 0, 8,  0, 0, 0);
      add(1, 0, 1, 1, 0, 7,  0, 0, 0);   // both stalks together
      add(1, 0, 1, 1, 0, 3,  0, 0, 0);
      add(1, 0, 0, 0, 0, 8,  0, 0, 0);
      add(1, 1, 0, 1, 0, 7,  1, 0, 1);   // reset while RIGHT and brake
      add(0, 0, 0, 0, 0, 1,  0, 0, 0);
      add(1, 0, 0, 0, 0, 8,  0, 0, 0);

      tick(3);
      chk_all("reset", 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         rst_n = vecs[i].rst;
         bus.brake_sw_i = vecs[i].brk;
         bus.stalk_left_i = vecs[i].sl;
         bus.stalk_right_i = vecs[i].sr;
         bus.cancel_i = vecs[i].cx;
         tick(int'(vecs[i].n));
         chk_all($sformatf("vec%0d", i), vecs[i].eb, vecs[i].el, vecs[i].er);
      end
      rst_n = 1'b1;
      bus.brake_sw_i = 1'b0; bus.stalk_left_i = 1'b0;
      bus.stalk_right_i = 1'b0; bus.cancel_i = 1'b0;

      // Short bounces never reach the output
      for (int p = 0; p < 5; p++) begin
         bus.brake_sw_i = 1'b1;
         for (int k = 0; k < 3; k++) begin tick(1); chk($sformatf("bounce%0d_hi", p), bus.brake, 1'b0); end
         bus.brake_sw_i = 1'b0;
         for (int k = 0; k < 3; k++) begin tick(1); chk($sformatf("bounce%0d_lo", p), bus.brake, 1'b0); end
      end
      tick(4);
      bus.brake_sw_i = 1'b1;
      tick(4);
      chk("pulse4_e4", bus.brake, 1'b0);
      bus.brake_sw_i = 1'b0;
      tick(1);
      chk("pulse4_e5", bus.brake, 1'b0);
      tick(1);
      chk("pulse4_e6", bus.brake, 1'b1);
      tick(3);
      chk("pulse4_e9", bus.brake, 1'b1);
      tick(1);
      chk("pulse4_e10", bus.brake, 1'b0);
      tick(6);

`ifdef TURN_BRAKE_HAZARD_EN
      bus.stalk_left_i = 1'b1;
      tick(7);
      chk_all("hz_left", 1'b0, 1'b1, 1'b0);
      bus.hazard_sw_i = 1'b1;
      tick(5);
      chk_all("hz_on_e5", 1'b0, 1'b1, 1'b0);
      tick(1);
      chk_all("hz_on_e6", 1'b0, 1'b1, 1'b1);
      tick(10);
      chk_all("hz_hold", 1'b0, 1'b1, 1'b1);
      bus.hazard_sw_i = 1'b0;
      tick(5);
      chk_all("hz_off_e5", 1'b0, 1'b1, 1'b1);
      tick(1);
      chk_all("hz_off_e6", 1'b0, 1'b0, 1'b0);
      bus.stalk_left_i = 1'b0;
      tick(8);
      chk_all("hz_idle", 1'b0, 1'b0, 1'b0);
      bus.stalk_left_i = 1'b1;
      tick(7);
      chk_all("hz_relatch", 1'b0, 1'b1, 1'b0);
      bus.stalk_left_i = 1'b0;
      bus.cancel_i = 1'b1;
      tick(1);
      bus.cancel_i = 1'b0;
      chk_all("hz_cancel", 1'b0, 1'b0, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
